inst_encoder: RTL

//  Encoder/writer counterpart of the control-unit decoder. Accepts instruction

---
 rtl/inst_enc_pkg.sv | 39 +++
 rtl/inst_pack.sv | 55 +++++
 rtl/inst_encoder.sv | 116 +++++++++++
 3 files changed

// File: rtl/inst_enc_pkg.sv
// Shared constants and types for the RV32I instruction encoder:
// opcodes, funct fields, request codes, the NOP word and the FSM states.
package inst_enc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [1:0] REQ_R   = 2'b00;
  localparam logic [1:0] REQ_LW  = 2'b01;
  localparam logic [1:0] REQ_SW  = 2'b10;
  localparam logic [1:0] REQ_BEQ = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // addi x0, x0, 0 -- substituted for any request whose immediate cannot be encoded
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ENC  = 2'd1,
    S_WR   = 2'd2,
    S_FULL = 2'd3
  } enc_state_e;

endpackage

// File: rtl/inst_pack.sv
// Combinational field packer: turns a decoded request into an RV32I word and
// flags immediates that do not fit the chosen instruction format.
module inst_pack
  import inst_enc_pkg::*;
(
  input  logic [1:0]  i_op,
  input  logic [1:0]  i_alu,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [12:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_bad
);

  logic [31:0] w_raw;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;

  // Pack fields per format; out-of-range immediates fall back to a NOP
  always_comb begin
    w_raw = NOP_WORD;
    o_bad = 1'b0;
    w_f3  = F3_ADD_SUB;
    w_f7  = F7_BASE;
    unique case (i_op)
      REQ_R: begin
        unique case (i_alu)
          ALU_ADD: begin w_f3 = F3_ADD_SUB; w_f7 = F7_BASE; end
          ALU_SUB: begin w_f3 = F3_ADD_SUB; w_f7 = F7_SUB;  end
          ALU_AND: begin w_f3 = F3_AND;     w_f7 = F7_BASE; end
          ALU_OR:  begin w_f3 = F3_OR;      w_f7 = F7_BASE; end
        endcase
        w_raw = {w_f7, i_rs2, i_rs1, w_f3, i_rd, OP_R};
      end
      REQ_LW: begin
        // 12-bit immediate: bit 12 must be a copy of the sign bit 11
        o_bad = i_imm[12] ^ i_imm[11];
        w_raw = {i_imm[11:0], i_rs1, F3_WORD, i_rd, OP_LOAD};
      end
      REQ_SW: begin
        o_bad = i_imm[12] ^ i_imm[11];
        w_raw = {i_imm[11:5], i_rs2, i_rs1, F3_WORD, i_imm[4:0], OP_STORE};
      end
      REQ_BEQ: begin
        // Branch offsets are in halfwords; an odd byte offset cannot be encoded
        o_bad = i_imm[0];
        w_raw = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BEQ,
                 i_imm[4:1], i_imm[11], OP_BRANCH};
      end
    endcase
    o_word = o_bad ? NOP_WORD : w_raw;
  end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder/writer: accepts requests over valid/ready, packs them
// into RV32I words and writes them sequentially into instruction memory.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [1:0]        req_alu,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [12:0]       req_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_imm
);

  localparam logic [ADDR_W:0] CNT_ONE  = 1;
  localparam logic [ADDR_W:0] CNT_LAST = (CNT_ONE << ADDR_W) - CNT_ONE;

  enc_state_e r_state, w_next;

  logic [1:0]      r_op, r_alu;
  logic [4:0]      r_rd, r_rs1, r_rs2;
  logic [12:0]     r_imm;
  logic [31:0]     r_word;
  logic [ADDR_W:0] r_count;
  logic            r_err;

  logic [31:0]     w_word;
  logic            w_bad;
  logic            w_accept;

  assign w_accept = req_valid && req_ready;

  inst_pack u_pack (
    .i_op   (r_op),
    .i_alu  (r_alu),
    .i_rd   (r_rd),
    .i_rs1  (r_rs1),
    .i_rs2  (r_rs2),
    .i_imm  (r_imm),
    .o_word (w_word),
    .o_bad  (w_bad)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; start overrides everything and drops any in-flight word
  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_accept) w_next = S_ENC;
        S_ENC:  w_next = S_WR;
        S_WR:   w_next = (r_count == CNT_LAST) ? S_FULL : S_IDLE;
        S_FULL: w_next = S_FULL;
      endcase
    end
  end

  // Outputs decoded from state; ready is held low while reset is asserted
  always_comb begin
    req_ready  = rst && (r_state == S_IDLE) && !start;
    imem_we    = (r_state == S_WR) && !start;
    imem_wdata = (r_state == S_WR) ? r_word : 32'h0;
    full       = (r_state == S_FULL);
  end

  assign imem_addr = r_count[ADDR_W-1:0];
  assign count     = r_count;
  assign err_imm   = r_err;

  // Word counter (doubles as write pointer) and sticky immediate-error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (start) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_ENC && w_bad) r_err   <= 1'b1;
      if (r_state == S_WR)           r_count <= r_count + CNT_ONE;
    end
  end

  // Request field latch and packed-word register
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op  <= req_op;
      r_alu <= req_alu;
      r_rd  <= req_rd;
      r_rs1 <= req_rs1;
      r_rs2 <= req_rs2;
      r_imm <= req_imm;
    end
    if (r_state == S_ENC) r_word <= w_word;
  end

endmodule
